// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-enabled load/store over a req/ack data-memory port,
// load alignment/extension, MEM/WB register, stall and timeout/misalign pulses.
module mem_access_stage #(
  parameter int DMEM_ADDR_W = 10,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   debug,
  input  logic [31:0]            EX_MEM_alures,
  input  logic [31:0]            EX_MEM_dout_rs2,
  input  logic                   EX_MEM_memread,
  input  logic                   EX_MEM_memwrite,
  input  logic                   EX_MEM_regwrite,
  input  logic [4:0]             EX_MEM_rd,
  input  logic [4:0]             EX_MEM_loadcntrl,
  input  logic [2:0]             EX_MEM_storecntrl,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   mem_stall,
  output logic                   MEM_WB_regwrite,
  output logic [4:0]             MEM_WB_rd,
  output logic [31:0]            WB_res,
  output logic                   mem_misalign,
  output logic                   mem_fault
);

  typedef enum logic { ST_IDLE, ST_WAIT } state_t;
  typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } size_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;

  logic       access, misaligned;
  size_t      ld_size, st_size, acc_size;
  logic       ld_signed;
  logic [3:0] be_calc;
  logic [31:0] wdata_calc, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic req, complete, abort, wb_pass, misalign_ev;

  assign access = EX_MEM_memread | EX_MEM_memwrite;

  // Lowest set control bit wins; an all-zero control field means a full word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ld_size   = SZ_W;
    ld_signed = 1'b0;
    if (EX_MEM_loadcntrl[0])      begin ld_size = SZ_B; ld_signed = 1'b1; end
    else if (EX_MEM_loadcntrl[1]) begin ld_size = SZ_H; ld_signed = 1'b1; end
    else if (EX_MEM_loadcntrl[2]) ld_size = SZ_W;
    else if (EX_MEM_loadcntrl[3]) ld_size = SZ_B;
    else if (EX_MEM_loadcntrl[4]) ld_size = SZ_H;

    st_size = SZ_W;
    if (EX_MEM_storecntrl[0])      st_size = SZ_B;
    else if (EX_MEM_storecntrl[1]) st_size = SZ_H;
  end

  // A store takes precedence when both memread and memwrite are set.
  assign acc_size   = EX_MEM_memwrite ? st_size : ld_size;
  assign misaligned = access &&
                      (((acc_size == SZ_H) && EX_MEM_alures[0]) ||
                       ((acc_size == SZ_W) && (EX_MEM_alures[1:0] != 2'b00)));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = EX_MEM_dout_rs2;
    case (st_size)
      SZ_B: begin
        be_calc    = 4'b0001 << EX_MEM_alures[1:0];
        wdata_calc = {4{EX_MEM_dout_rs2[7:0]}};
      end
      SZ_H: begin
        be_calc    = EX_MEM_alures[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{EX_MEM_dout_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sel = dmem_rdata[{EX_MEM_alures[1:0], 3'b000} +: 8];
  assign half_sel = EX_MEM_alures[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_data = dmem_rdata;
    case (ld_size)
      SZ_B:    load_data = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{16{ld_signed & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req         = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    wb_pass     = 1'b0;
    misalign_ev = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!debug) begin
          if (!access) begin
            wb_pass = 1'b1;
          end else if (misaligned) begin
            misalign_ev = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_ack) begin
              complete = 1'b1;
            end else begin
              state_n = ST_WAIT;
              cnt_n   = 8'd0;
            end
          end
        end
      end
      ST_WAIT: begin
        // debug is deliberately ignored here so the in-flight access can finish.
        req = 1'b1;
        if (dmem_ack) begin
          complete = 1'b1;
          state_n  = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign dmem_req   = req;
  assign dmem_we    = req & EX_MEM_memwrite;
  assign dmem_be    = (req && EX_MEM_memwrite) ? be_calc : 4'b0000;
  assign dmem_wdata = wdata_calc;
  assign dmem_addr  = EX_MEM_alures[DMEM_ADDR_W+1:2];
  assign mem_stall  = req & ~dmem_ack & ~abort;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Rst) begin
      state           <= ST_IDLE;
      cnt             <= 8'd0;
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_rd       <= 5'd0;
      WB_res          <= 32'd0;
      mem_misalign    <= 1'b0;
      mem_fault       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      mem_misalign <= misalign_ev;
      mem_fault    <= abort;
      if (complete) begin
        MEM_WB_rd       <= EX_MEM_rd;
        MEM_WB_regwrite <= EX_MEM_regwrite;
        WB_res          <= EX_MEM_memwrite ? EX_MEM_alures : load_data;
      end else if (wb_pass) begin
        MEM_WB_rd       <= EX_MEM_rd;
        MEM_WB_regwrite <= EX_MEM_regwrite;
        WB_res          <= EX_MEM_alures;
      end else if (misalign_ev) begin
        MEM_WB_rd       <= EX_MEM_rd;
        MEM_WB_regwrite <= 1'b0;
      end else if (req) begin
        // Stall or abort: insert a bubble, keep rd/result.
        MEM_WB_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboard of expected MEM/WB
// contents plus inline checks of the memory-port handshake.
module tb_mem_access_stage;
  localparam int AW = 10;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          Rst, debug;
  logic [31:0]   EX_MEM_alures, EX_MEM_dout_rs2;
  logic          EX_MEM_memread, EX_MEM_memwrite, EX_MEM_regwrite;
  logic [4:0]    EX_MEM_rd, EX_MEM_loadcntrl;
  logic [2:0]    EX_MEM_storecntrl;
  logic          dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_wdata, dmem_rdata, WB_res;
  logic          MEM_WB_regwrite, mem_misalign, mem_fault;
  logic [4:0]    MEM_WB_rd;

  mem_access_stage #(.DMEM_ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .Rst(Rst), .debug(debug),
    .EX_MEM_alures(EX_MEM_alures), .EX_MEM_dout_rs2(EX_MEM_dout_rs2),
    .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memwrite(EX_MEM_memwrite),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_loadcntrl(EX_MEM_loadcntrl), .EX_MEM_storecntrl(EX_MEM_storecntrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_rd(MEM_WB_rd), .WB_res(WB_res),
    .mem_misalign(mem_misalign), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] res;
  } wb_t;

  wb_t sb_q[$];
  wb_t m_wb;           // what MEM/WB should hold once the last driven op is clocked in
  wb_t exp_wb, got_wb;
  int  n_cmp = 0, n_err = 0;

  assign got_wb = {MEM_WB_rd, MEM_WB_regwrite, WB_res};

  task automatic set_in(input logic rd_en, input logic wr_en, input logic rw,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] lc,
                        input logic [2:0] sc);
    EX_MEM_memread    = rd_en;
    EX_MEM_memwrite   = wr_en;
    EX_MEM_regwrite   = rw;
    EX_MEM_rd         = rd;
    EX_MEM_alures     = alu;
    EX_MEM_dout_rs2   = rs2;
    EX_MEM_loadcntrl  = lc;
    EX_MEM_storecntrl = sc;
  endtask

  // Idle ALU op with regwrite=0: clocks zeros into MEM/WB.
  task automatic nop();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 3'd0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    m_wb       = '0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    wb_t e;
    e = {rd, rw, res};
    sb_q.push_back(e);
    m_wb = e;
  endtask

  task automatic pop_into(output wb_t e);
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    Rst = 1'b1; debug = 1'b0; nop();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({got_wb, mem_misalign, mem_fault, dmem_req, dmem_we, mem_stall, dmem_be} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got wb=%h mis=%b flt=%b req=%b we=%b stall=%b be=%b, want all zero",
               got_wb, mem_misalign, mem_fault, dmem_req, dmem_we, mem_stall, dmem_be);
    end
    @(negedge clk); Rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'd0, 5'd0, 3'd0);
    push_exp(5'd5, 1'b1, 32'h1234_5678);
    #1; n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL alu_no_req: got req=%b stall=%b, want 0 0", dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb) begin
      n_err++; $display("FAIL alu_wb: got %h want %h", got_wb, exp_wb);
    end
    @(negedge clk); nop();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      @(negedge clk);
      v = $urandom();
      set_in(1'b0, 1'b0, i[0], 5'(i + 1), v, 32'd0, 5'd0, 3'd0);
      push_exp(5'(i + 1), i[0], v);
      @(posedge clk); #1;
      pop_into(exp_wb); n_cmp++;
      if (got_wb !== exp_wb) begin
        n_err++; $display("FAIL b2b_wb[%0d]: got %h want %h", i, got_wb, exp_wb);
      end
    end
    @(negedge clk); nop();
  endtask

  task automatic test_sb_zero_wait();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 5'd2, 32'h0000_0007, 32'h0000_00AB, 5'd0, 3'b001);
    dmem_ack = 1'b1;
    push_exp(5'd2, 1'b0, 32'h0000_0007);
    #1; n_cmp++;
    if ({dmem_req, dmem_we, mem_stall, dmem_addr, dmem_be, dmem_wdata} !==
        {1'b1, 1'b1, 1'b0, 10'd1, 4'b1000, 32'hABAB_ABAB}) begin
      n_err++;
      $display("FAIL sb_port: got req=%b we=%b stall=%b addr=%0d be=%b wd=%h, want 1 1 0 1 1000 abababab",
               dmem_req, dmem_we, mem_stall, dmem_addr, dmem_be, dmem_wdata);
    end
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb) begin
      n_err++; $display("FAIL sb_wb: got %h want %h", got_wb, exp_wb);
    end
    @(negedge clk); nop();
  endtask

  task automatic test_store_lanes();
    logic [31:0] addr, rs2, want_wd;
    logic [3:0]  want_be;
    logic [2:0]  sc;
    logic [7:0]  b;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 4) begin
        addr = 32'h100 + 32'(i); rs2 = 32'h1234_56C0 + 32'(i); sc = 3'b001;
        b = 8'hC0 + 8'(i); want_be = 4'b0001 << i; want_wd = {b, b, b, b};
      end else if (i < 6) begin
        addr = (i == 4) ? 32'h200 : 32'h202; rs2 = 32'hAAAA_5A5A; sc = 3'b010;
        want_be = (i == 4) ? 4'b0011 : 4'b1100; want_wd = 32'h5A5A_5A5A;
      end else begin
        addr = 32'h304; rs2 = 32'h0BAD_F00D; sc = 3'b100;
        want_be = 4'b1111; want_wd = 32'h0BAD_F00D;
      end
      set_in(1'b0, 1'b1, 1'b0, 5'd4, addr, rs2, 5'd0, sc);
      dmem_ack = 1'b1;
      push_exp(5'd4, 1'b0, addr);
      #1; n_cmp++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
          {1'b1, 1'b1, addr[AW+1:2], want_be, want_wd}) begin
        n_err++;
        $display("FAIL store_lane[%0d]: got req=%b we=%b addr=%h be=%b wd=%h, want 1 1 %h %b %h",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, addr[AW+1:2], want_be, want_wd);
      end
      @(posedge clk); #1;
      pop_into(exp_wb); n_cmp++;
      if (got_wb !== exp_wb) begin
        n_err++; $display("FAIL store_wb[%0d]: got %h want %h", i, got_wb, exp_wb);
      end
    end
    @(negedge clk); nop();
  endtask

  typedef struct {
    logic [4:0]  lc;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] want;
  } ld_vec_t;

  task automatic test_loads_zero_wait();
    ld_vec_t tab[8];
    tab[0] = '{5'b00010, 32'h2, 32'h8001_7FFF, 32'hFFFF_8001};  // LH upper
    tab[1] = '{5'b10000, 32'h2, 32'h8001_7FFF, 32'h0000_8001};  // LHU upper
    tab[2] = '{5'b00010, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF};  // LH lower
    tab[3] = '{5'b00100, 32'h4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};  // LW
    tab[4] = '{5'b01000, 32'h3, 32'hF100_0000, 32'h0000_00F1};  // LBU lane 3
    tab[5] = '{5'b00001, 32'h1, 32'h0000_7F00, 32'h0000_007F};  // LB positive
    tab[6] = '{5'b00000, 32'h8, 32'h1357_2468, 32'h1357_2468};  // empty -> LW
    tab[7] = '{5'b00011, 32'h0, 32'h0000_00FF, 32'hFFFF_FFFF};  // LB beats LH
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b1, 5'(10 + i), tab[i].addr, 32'd0, tab[i].lc, 3'd0);
      dmem_rdata = tab[i].rdata;
      dmem_ack   = 1'b1;
      push_exp(5'(10 + i), 1'b1, tab[i].want);
      #1; n_cmp++;
      if ({dmem_req, dmem_we, dmem_be, mem_stall} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
        n_err++;
        $display("FAIL load_port[%0d]: got req=%b we=%b be=%b stall=%b, want 1 0 0000 0",
                 i, dmem_req, dmem_we, dmem_be, mem_stall);
      end
      @(posedge clk); #1;
      pop_into(exp_wb); n_cmp++;
      if (got_wb !== exp_wb) begin
        n_err++; $display("FAIL load_wb[%0d]: got %h want %h", i, got_wb, exp_wb);
      end
    end
    @(negedge clk); nop();
  endtask

  task automatic test_load_wait(input string name, input logic [4:0] lc, input logic [31:0] want);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 5'd7, 32'h2, 32'd0, lc, 3'd0);
    dmem_rdata = 32'h0080_0000;
    dmem_ack   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; n_cmp++;
      if (mem_stall !== 1'b1 || dmem_req !== 1'b1) begin
        n_err++; $display("FAIL %s_stall[%0d]: got stall=%b req=%b, want 1 1", name, c, mem_stall, dmem_req);
      end
      @(posedge clk); #1; n_cmp++;
      if (got_wb !== {m_wb.rd, 1'b0, m_wb.res}) begin
        n_err++; $display("FAIL %s_bubble[%0d]: got %h want %h", name, c, got_wb, {m_wb.rd, 1'b0, m_wb.res});
      end
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    push_exp(5'd7, 1'b1, want);
    #1; n_cmp++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
      n_err++; $display("FAIL %s_ack_cycle: got stall=%b req=%b, want 0 1", name, mem_stall, dmem_req);
    end
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb) begin
      n_err++; $display("FAIL %s_wb: got %h want %h", name, got_wb, exp_wb);
    end
    @(negedge clk); nop();
  endtask

  task automatic test_misalign(input string name, input logic rd_en, input logic wr_en,
                               input logic [4:0] lc, input logic [2:0] sc, input logic [31:0] addr);
    @(negedge clk);
    set_in(rd_en, wr_en, 1'b1, 5'd12, addr, 32'h1, lc, sc);
    dmem_ack = 1'b0;
    push_exp(5'd12, 1'b0, m_wb.res);
    #1; n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL %s_no_req: got req=%b stall=%b, want 0 0", name, dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb || mem_misalign !== 1'b1) begin
      n_err++; $display("FAIL %s_pulse: got wb=%h mis=%b want wb=%h mis=1", name, got_wb, mem_misalign, exp_wb);
    end
    @(negedge clk); nop();
    @(posedge clk); #1; n_cmp++;
    if (mem_misalign !== 1'b0) begin
      n_err++; $display("FAIL %s_pulse_end: got mis=%b want 0", name, mem_misalign);
    end
  endtask

  task automatic test_timeout();
    int stalls;
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 5'd20, 32'h40, 32'd0, 5'b00100, 3'd0);
    dmem_ack = 1'b0;
    stalls = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (mem_stall !== 1'b1) break;
      stalls++;
      @(negedge clk);
    end
    n_cmp++;
    if (stalls != TO) begin
      n_err++; $display("FAIL timeout_stall_len: got %0d cycles want %0d", stalls, TO);
    end
    @(posedge clk); #1; n_cmp++;
    if (mem_fault !== 1'b1 || got_wb !== {m_wb.rd, 1'b0, m_wb.res}) begin
      n_err++; $display("FAIL timeout_fault: got flt=%b wb=%h want flt=1 wb=%h", mem_fault, got_wb, {m_wb.rd, 1'b0, m_wb.res});
    end
    @(negedge clk); nop();
    #1; n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL timeout_idle: got req=%b stall=%b want 0 0", dmem_req, mem_stall);
    end
    @(posedge clk); #1; n_cmp++;
    if (mem_fault !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse_end: got flt=%b want 0", mem_fault);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 5'd21, 32'h44, 32'd0, 5'b00100, 3'd0);
    dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1; n_cmp++;
    if (mem_stall !== 1'b1) begin
      n_err++; $display("FAIL rst_wait_pre: got stall=%b want 1", mem_stall);
    end
    Rst = 1'b1; nop();
    @(posedge clk); #1; n_cmp++;
    if ({got_wb, mem_misalign, mem_fault, dmem_req, dmem_we, mem_stall, dmem_be} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_values: got wb=%h mis=%b flt=%b req=%b we=%b stall=%b be=%b, want all zero",
               got_wb, mem_misalign, mem_fault, dmem_req, dmem_we, mem_stall, dmem_be);
    end
    @(negedge clk); Rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 5'd3, 32'h55, 32'd0, 5'd0, 3'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    push_exp(5'd3, 1'b0, 32'h55);
    #1; n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL rst_late_ack_port: got req=%b stall=%b want 0 0", dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb || mem_fault !== 1'b0) begin
      n_err++; $display("FAIL rst_late_ack_wb: got wb=%h flt=%b want wb=%h flt=0", got_wb, mem_fault, exp_wb);
    end
    @(negedge clk); nop();
  endtask

  task automatic test_debug();
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 32'd0, 5'd0, 3'd0);
    push_exp(5'd9, 1'b1, 32'hCAFE_F00D);
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb) begin
      n_err++; $display("FAIL dbg_setup_wb: got %h want %h", got_wb, exp_wb);
    end
    @(negedge clk);
    debug = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 5'd22, 32'h80, 32'd0, 5'b00100, 3'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    #1; n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++; $display("FAIL dbg_no_req: got req=%b stall=%b want 0 0", dmem_req, mem_stall);
    end
    repeat (2) @(posedge clk);
    #1; n_cmp++;
    if (got_wb !== m_wb) begin
      n_err++; $display("FAIL dbg_hold: got %h want %h", got_wb, m_wb);
    end
    // Release debug without ack so the load parks in WAIT, then raise debug again.
    @(negedge clk); debug = 1'b0; dmem_ack = 1'b0;
    @(negedge clk); debug = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h2468_ACE0;
    push_exp(5'd22, 1'b1, 32'h2468_ACE0);
    #1; n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_err++; $display("FAIL dbg_wait_req: got req=%b want 1", dmem_req);
    end
    @(posedge clk); #1;
    pop_into(exp_wb); n_cmp++;
    if (got_wb !== exp_wb) begin
      n_err++; $display("FAIL dbg_wait_wb: got %h want %h", got_wb, exp_wb);
    end
    @(negedge clk); debug = 1'b0; nop();
  endtask

  initial begin
    Rst = 1'b1; debug = 1'b0; nop();
    test_reset();
    test_alu();
    test_back_to_back();
    test_sb_zero_wait();
    test_store_lanes();
    test_loads_zero_wait();
    test_load_wait("lb_wait",  5'b00001, 32'hFFFF_FF80);
    test_load_wait("lbu_wait", 5'b01000, 32'h0000_0080);
    test_misalign("lh_mis", 1'b1, 1'b0, 5'b00010, 3'd0, 32'h1);
    test_misalign("sw_mis", 1'b0, 1'b1, 5'd0, 3'b100, 32'h6);
    test_timeout();
    test_reset_in_wait();
    test_debug();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between the execute stage's EX/MEM register and write-back. It issues byte-enabled load/store requests to the data memory over a req/ack handshake, aligns and sign/zero-extends load data, and selects the ALU result for non-memory instructions. It registers the MEM/WB outputs (rd, regwrite, result) and drives a stall to the hazard logic while a memory access is outstanding.

## Interface
- DMEM_ADDR_W, 10: word-address width of data memory.
- TIMEOUT, 15: maximum WAIT cycles without ack before abort (1..255).
- clk  in  1  clock
- Rst  in  1  synchronous active-high reset; reset Rst, synchronous, active-high; clock clk.
- debug  in  1  freezes MEM/WB register and blocks new requests.
- EX_MEM_alures  in  32  ALU result / byte address.
- EX_MEM_dout_rs2  in  32  store data.
- EX_MEM_memread, EX_MEM_memwrite, EX_MEM_regwrite  in  1 each.
- EX_MEM_rd  in  5  destination register.
- EX_MEM_loadcntrl  in  5  one-hot: [0]LB [1]LH [2]LW [3]LBU [4]LHU.
- EX_MEM_storecntrl  in  3  one-hot: [0]SB [1]SH [2]SW.
- dmem_req  out  1  access request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DMEM_ADDR_W  = EX_MEM_alures[DMEM_ADDR_W+1:2].
- dmem_be  out  4  byte enables (write only; 4'b0000 on reads).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word, valid with ack.
- dmem_ack  in  1  completes the request in the same cycle.
- mem_stall  out  1  upstream stages must hold.
- MEM_WB_regwrite  out  1; MEM_WB_rd  out  5; WB_res  out  32.
- mem_misalign  out  1  one-cycle pulse on a misaligned access.
- mem_fault  out  1  one-cycle pulse on a timeout abort.

## Operation
- Access = memwrite | memread. When both are set, the write wins and the read is ignored.
- Decode: lowest set bit wins. All-zero loadcntrl is treated as LW; all-zero storecntrl as SW.
- Misaligned when halfword and addr[0]=1, or word and addr[1:0]≠0.
  - No request is issued.
  - Next edge: MEM_WB_regwrite←0, MEM_WB_rd←EX_MEM_rd, mem_misalign←1.
- Store lanes, with lane = addr[1:0]:
  - SB: be = 1<<lane, wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Load extraction:
  - LB/LBU take rdata[8*lane+7 : 8*lane], sign-/zero-extended.
  - LH/LHU take rdata[16*addr[1]+15 : 16*addr[1]], sign-/zero-extended.
  - LW takes rdata.
- FSM states: IDLE, WAIT.
  - IDLE with an aligned access and !debug: dmem_req=1 combinationally.
    - If dmem_ack the same cycle: complete and stay in IDLE.
    - Otherwise go to WAIT and clear the counter.
  - WAIT: dmem_req=1; address, be and wdata are held stable (EX/MEM is frozen by mem_stall).
    - On ack: complete and go to IDLE.
    - Counter increments each cycle without ack. On reaching TIMEOUT: abort, mem_fault←1, MEM_WB_regwrite←0, go to IDLE.
- mem_stall = dmem_req & !dmem_ack. It stays 0 during a timeout-abort cycle.
- Complete (registered):
  - MEM_WB_rd←EX_MEM_rd, MEM_WB_regwrite←EX_MEM_regwrite.
  - WB_res←extracted load data for a read; EX_MEM_alures for a write.
- Non-access instruction with !debug: next edge MEM_WB_rd←EX_MEM_rd, MEM_WB_regwrite←EX_MEM_regwrite, WB_res←EX_MEM_alures.
- Stall cycles: MEM_WB_regwrite←0 (bubble); WB_res and MEM_WB_rd hold.
- debug=1 in IDLE: no request is issued and the MEM/WB registers hold. debug is ignored in WAIT, so an in-flight access completes normally.
- dmem_ack while in IDLE with no request is ignored.

## Timing
- Reset values: state IDLE, counter 0, MEM_WB_regwrite 0, MEM_WB_rd 0, WB_res 0, mem_misalign 0, mem_fault 0. dmem_req, dmem_we, mem_stall and dmem_be are 0 after reset.
- Non-memory op: 1-cycle latency, EX/MEM → MEM/WB.
- Zero-wait memory (ack in the issue cycle): 1-cycle latency, no stall.
- Ack N cycles after issue: mem_stall high for N cycles; the result appears at the edge of the ack cycle + 1.
- Rst during WAIT: after the reset edge, dmem_req=0, state IDLE, and any later ack is ignored.
- Pulses (mem_misalign, mem_fault) last exactly one cycle unless the condition repeats.

## Test plan
- ALU op, alures=0x12345678, rd=5, regwrite=1 → next cycle WB_res=0x12345678, MEM_WB_rd=5, MEM_WB_regwrite=1, dmem_req never asserted.
- SB at addr 0x0000_0007, rs2=0x000000AB, ack same cycle:
  - Same cycle: dmem_addr=1, be=1000, wdata=0xABABABAB, we=1, stall=0.
  - Next cycle: MEM_WB_regwrite=0.
- LB at addr 0x2, rdata=0x0080_0000, ack after 3 cycles:
  - mem_stall=1 for 3 cycles with MEM_WB_regwrite=0 bubbles.
  - Then WB_res=0xFFFFFF80. LBU with the same stimulus gives 0x00000080.
- LH at 0x1 and SW at 0x6 → no dmem_req, mem_misalign pulses 1 cycle each, MEM_WB_regwrite=0.
- LW with no ack and TIMEOUT=15 → stall for 15 cycles, then mem_fault pulse, MEM_WB_regwrite=0, state IDLE, stall=0.
- Two boundary checks:
  - Rst asserted mid-WAIT: the next cycle has dmem_req=0 and all outputs at reset values.
  - debug=1 with a pending LW in IDLE: no request issued, MEM/WB outputs unchanged.
